// File: rtl/io_bus_reg_slave.sv
// Register-bank slave for the 32-bit IO bus: address-window decode, four-phase handshake_1/handshake_2.
// Optional feature macro IO_BUS_SYNC_EN inserts a 2-flop synchroniser on handshake_1.
module io_bus_reg_slave #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           NUM_REGS   = 8,
  parameter int unsigned           BASE_ADDR  = 0,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] REG_RESET  = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          data_out,
  output logic [DATA_WIDTH-1:0]          data_in,
  input  logic [ADDR_WIDTH-1:0]          reg_address,
  input  logic                           RW,
  input  logic                           handshake_1,
  output logic                           handshake_2,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]            wr_strobe,
  output logic [NUM_REGS-1:0]            rd_strobe
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);

  logic                                h1_s;
  logic                                h1_r;
  logic [1:0]                          state_r;
  logic [NUM_REGS-1:0]                 sel_s;
  logic [NUM_REGS-1:0]                 sel_r;
  logic                                rw_r;
  logic [DATA_WIDTH-1:0]               data_r;
  logic [DATA_WIDTH-1:0]               rd_data_s;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_r;
  logic                                hs2_r;
  logic [DATA_WIDTH-1:0]               data_in_r;
  logic [NUM_REGS-1:0]                 wr_strobe_r;
  logic [NUM_REGS-1:0]                 rd_strobe_r;
  logic [31:0]                         addr_u_s;
  logic                                hit_s;
  logic [ADDR_WIDTH-1:0]               idx_s;

`ifdef IO_BUS_SYNC_EN
  logic [1:0] h1_sync_r;

  // Two-flop synchroniser for an asynchronous master request
  always_ff @(posedge clk) begin
    if (reset) begin
      h1_sync_r <= 2'b00;
    end else begin
      h1_sync_r <= {h1_sync_r[0], handshake_1};
    end
  end
  assign h1_s = h1_sync_r[1];
`else
  assign h1_s = handshake_1;
`endif

  // Request sample flop: the FSM acts on the value captured at the previous edge
  always_ff @(posedge clk) begin
    if (reset) begin
      h1_r <= 1'b0;
    end else begin
      h1_r <= h1_s;
    end
  end

  assign addr_u_s = 32'(reg_address);
  assign hit_s    = (addr_u_s >= BASE_ADDR) && (addr_u_s < (BASE_ADDR + NUM_REGS));
  assign idx_s    = reg_address - BASE_A;

  // One-hot register select for the current bus address
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      sel_s[i] = (idx_s == ADDR_WIDTH'(i));
    end
  end

  // Read mux over the latched select: status source for read-only slots
  always_comb begin
    rd_data_s = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      rd_data_s = rd_data_s | ({DATA_WIDTH{sel_r[i]}} &
                  (RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_r[i]));
    end
  end

  // Handshake FSM, register bank, strobes and registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      sel_r       <= '0;
      rw_r        <= 1'b0;
      data_r      <= '0;
      hs2_r       <= 1'b0;
      data_in_r   <= '0;
      wr_strobe_r <= '0;
      rd_strobe_r <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_r[i] <= RO_MASK[i] ? '0 : REG_RESET;
      end
    end else begin
      wr_strobe_r <= '0;
      rd_strobe_r <= '0;
      case (state_r)
        ST_IDLE: begin
          if (h1_r && hit_s) begin
            state_r <= ST_ACCESS;
            sel_r   <= sel_s;
            rw_r    <= RW;
            data_r  <= data_out;
            // Strobes are timed to coincide with the ACCESS cycle
            if (RW) begin
              rd_strobe_r <= sel_s;
            end else begin
              wr_strobe_r <= sel_s & ~RO_MASK;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (!rw_r && sel_r[i] && !RO_MASK[i]) begin
              regs_r[i] <= data_r;
            end else begin
              regs_r[i] <= regs_r[i];
            end
          end
          hs2_r     <= 1'b1;
          data_in_r <= rw_r ? rd_data_s : '0;
          state_r   <= ST_ACK;
        end
        ST_ACK: begin
          if (!h1_r) begin
            state_r   <= ST_IDLE;
            hs2_r     <= 1'b0;
            data_in_r <= '0;
          end else begin
            state_r <= ST_ACK;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          hs2_r     <= 1'b0;
          data_in_r <= '0;
        end
      endcase
    end
  end

  assign handshake_2 = hs2_r;
  assign data_in     = data_in_r;
  assign regs_out    = regs_r;
  assign wr_strobe   = wr_strobe_r;
  assign rd_strobe   = rd_strobe_r;

endmodule
